// File: rtl/muldiv_controller.sv
// ---------------------------------------------------------------------------
// muldiv_controller
//
// Iterative RV32M/RV64M multiply/divide unit that sits beside the EX-stage
// ALU. It decodes the ALU control fields itself, claims R-type ops with
// Funct7 = 0000001, then runs a radix-2 shift-add multiply or a restoring
// divide, one bit per cycle. The pipeline is stalled through busy until
// done pulses.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   ALUOp      controller op class (2'b10 = R-type / I-type)
//   Funct7     instruction bits 31:25
//   Funct3     instruction bits 14:12 (selects MUL..REMU)
//   start      issue the decoded op this cycle (taken only when idle)
//   flush      abort the op in flight (ignored when idle)
//   operand_a  rs1 value
//   operand_b  rs2 value
//   is_muldiv  combinational decode: the current fields select an M op
//   busy       op in flight, from the cycle after accept to done inclusive
//   done       one-cycle pulse, result valid in the same cycle
//   result     final result, held until the next completed op
//
// Parameters
//   XLEN       operand width, 32 or 64
//   EARLY_OUT  1: divide-by-zero and signed overflow finish without iterating
// ---------------------------------------------------------------------------
module muldiv_controller #(
   parameter int XLEN      = 32,
   parameter int EARLY_OUT = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   input  logic            start,
   input  logic            flush,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic            is_muldiv,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN + 1);

   localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
   localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
   localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIN  = 2'b10
   } state_t;

   // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
   function automatic logic op_signed_a(input logic [2:0] op);
      op_signed_a = (op == OP_MULH) || (op == OP_MULHSU) ||
                    (op == OP_DIV)  || (op == OP_REM);
   endfunction

   // rs2 is treated as signed for MULH, DIV and REM.
   function automatic logic op_signed_b(input logic [2:0] op);
      op_signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // Unsigned magnitude; the most-negative value maps to 2^(XLEN-1), which
   // still fits in XLEN unsigned bits.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                 input logic            neg);
      magnitude = neg ? -v : v;
   endfunction

   // Sign correction and result selection from the raw iteration state.
   // For multiply {hi,lo} is the unsigned product; for divide lo is the
   // quotient magnitude and hi the remainder magnitude.
   function automatic logic [XLEN-1:0] fin_value(
      input logic [2:0]      op,
      input logic            neg_a,
      input logic            neg_b,
      input logic            dz,
      input logic            ovf,
      input logic [XLEN-1:0] hi,
      input logic [XLEN-1:0] lo,
      input logic [XLEN-1:0] a_raw
   );
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   quot;
      logic [XLEN-1:0]   rem;
      logic [XLEN-1:0]   res;
      prod = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
      quot = (neg_a ^ neg_b) ? -lo : lo;
      rem  = neg_a ? -hi : hi;
      case (op)
         OP_MUL:                       res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              res = dz ? ALL_ONES : (ovf ? MOST_NEG : quot);
         OP_REM, OP_REMU:              res = dz ? a_raw : (ovf ? ZERO : rem);
         default:                      res = ZERO;
      endcase
      fin_value = res;
   endfunction

   state_t            state_r;
   state_t            state_nx_s;
   logic [2:0]        op_r;
   logic              sign_a_r;
   logic              sign_b_r;
   logic              dz_r;
   logic              ovf_r;
   logic [XLEN-1:0]   a_raw_r;
   logic [XLEN-1:0]   b_mag_r;
   logic [XLEN-1:0]   hi_r;
   logic [XLEN-1:0]   lo_r;
   logic [CW-1:0]     cnt_r;
   logic [XLEN-1:0]   fin_res_r;
   logic [XLEN-1:0]   result_r;

   logic              accept_s;
   logic              last_iter_s;
   logic              sign_a_in_s;
   logic              sign_b_in_s;
   logic [XLEN-1:0]   a_mag_in_s;
   logic [XLEN-1:0]   b_mag_in_s;
   logic              dz_in_s;
   logic              ovf_in_s;
   logic              early_s;
   logic [XLEN:0]     mul_sum_s;
   logic [XLEN:0]     div_sh_s;
   logic [XLEN:0]     div_diff_s;
   logic [XLEN-1:0]   hi_nx_s;
   logic [XLEN-1:0]   lo_nx_s;

   assign is_muldiv   = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
   assign last_iter_s = (cnt_r == CNT_ONE);

   assign sign_a_in_s = op_signed_a(Funct3) & operand_a[XLEN-1];
   assign sign_b_in_s = op_signed_b(Funct3) & operand_b[XLEN-1];
   assign a_mag_in_s  = magnitude(operand_a, sign_a_in_s);
   assign b_mag_in_s  = magnitude(operand_b, sign_b_in_s);
   assign dz_in_s     = Funct3[2] && (operand_b == ZERO);
   assign ovf_in_s    = ((Funct3 == OP_DIV) || (Funct3 == OP_REM)) &&
                        (operand_a == MOST_NEG) && (operand_b == ALL_ONES);
   assign early_s     = (EARLY_OUT != 32'sd0) && (dz_in_s || ovf_in_s);

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode plus busy/done; done is masked by flush so a flush in
   // the final cycle suppresses completion.
   always_comb begin
      state_nx_s = state_r;
      accept_s   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && is_muldiv) begin
               accept_s = 1'b1;
               if (early_s) begin
                  state_nx_s = FIN;
               end else begin
                  state_nx_s = CALC;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (flush) begin
               state_nx_s = IDLE;
            end else if (last_iter_s) begin
               state_nx_s = FIN;
            end else begin
               state_nx_s = CALC;
            end
         end
         FIN: begin
            busy       = 1'b1;
            done       = ~flush;
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // One iteration: shift-add for multiply, shift/trial-subtract for divide.
   always_comb begin
      mul_sum_s  = {1'b0, hi_r} + {1'b0, b_mag_r};
      div_sh_s   = {hi_r, lo_r[XLEN-1]};
      div_diff_s = div_sh_s - {1'b0, b_mag_r};
      hi_nx_s    = hi_r;
      lo_nx_s    = lo_r;
      if (op_r[2]) begin
         // Bit XLEN of the difference is set when the trial subtract underflows.
         if (!div_diff_s[XLEN]) begin
            {hi_nx_s, lo_nx_s} = {div_diff_s[XLEN-1:0], lo_r[XLEN-2:0], 1'b1};
         end else begin
            {hi_nx_s, lo_nx_s} = {div_sh_s[XLEN-1:0], lo_r[XLEN-2:0], 1'b0};
         end
      end else begin
         if (lo_r[0]) begin
            {hi_nx_s, lo_nx_s} = {mul_sum_s, lo_r[XLEN-1:1]};
         end else begin
            {hi_nx_s, lo_nx_s} = {1'b0, hi_r, lo_r[XLEN-1:1]};
         end
      end
   end

   // Operand latch, iteration state, final-value staging and result hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_r      <= 3'b000;
         sign_a_r  <= 1'b0;
         sign_b_r  <= 1'b0;
         dz_r      <= 1'b0;
         ovf_r     <= 1'b0;
         a_raw_r   <= ZERO;
         b_mag_r   <= ZERO;
         hi_r      <= ZERO;
         lo_r      <= ZERO;
         cnt_r     <= CNT_ZERO;
         fin_res_r <= ZERO;
         result_r  <= ZERO;
      end else if (accept_s) begin
         // Multiplier and dividend both start in lo; hi accumulates.
         op_r     <= Funct3;
         sign_a_r <= sign_a_in_s;
         sign_b_r <= sign_b_in_s;
         dz_r     <= dz_in_s;
         ovf_r    <= ovf_in_s;
         a_raw_r  <= operand_a;
         b_mag_r  <= b_mag_in_s;
         hi_r     <= ZERO;
         lo_r     <= a_mag_in_s;
         cnt_r    <= CNT_LOAD;
         if (early_s) begin
            fin_res_r <= fin_value(Funct3, sign_a_in_s, sign_b_in_s, dz_in_s,
                                   ovf_in_s, ZERO, ZERO, operand_a);
         end
      end else if ((state_r == CALC) && !flush) begin
         hi_r  <= hi_nx_s;
         lo_r  <= lo_nx_s;
         cnt_r <= cnt_r - CNT_ONE;
         if (last_iter_s) begin
            fin_res_r <= fin_value(op_r, sign_a_r, sign_b_r, dz_r, ovf_r,
                                   hi_nx_s, lo_nx_s, a_raw_r);
         end
      end else if ((state_r == FIN) && !flush) begin
         result_r <= fin_res_r;
      end
   end

   // The new value is visible in the done cycle; otherwise the held result.
   always_comb begin
      if (done) begin
         result = fin_res_r;
      end else begin
         result = result_r;
      end
   end

endmodule

// File: tb/tb_muldiv_controller.sv
module tb_muldiv_controller;

   localparam int XLEN = 32;
   localparam int LAT  = XLEN + 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  ALUOp;
   logic [6:0]  Funct7;
   logic [2:0]  Funct3;
   logic        start;
   logic        flush;
   logic [31:0] operand_a;
   logic [31:0] operand_b;

   logic        is_md0, busy0, done0;
   logic        is_md1, busy1, done1;
   logic [31:0] res0, res1;

   int checks   = 0;
   int failures = 0;

   int          mon_lat[2];
   int          mon_nd[2];
   int          mon_bcnt[2];
   int          mon_blast[2];
   logic [31:0] mon_res[2];
   logic [31:0] last_want;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] want;
      logic        fast;
   } vec_t;

   vec_t vecs[20];

   always #5 clk = ~clk;

   // index 0: iterating special cases, index 1: early-out
   muldiv_controller #(.XLEN(XLEN), .EARLY_OUT(0)) dut_slow (
      .clk(clk), .reset_n(reset_n), .ALUOp(ALUOp), .Funct7(Funct7),
      .Funct3(Funct3), .start(start), .flush(flush),
      .operand_a(operand_a), .operand_b(operand_b),
      .is_muldiv(is_md0), .busy(busy0), .done(done0), .result(res0));

   muldiv_controller #(.XLEN(XLEN), .EARLY_OUT(1)) dut_fast (
      .clk(clk), .reset_n(reset_n), .ALUOp(ALUOp), .Funct7(Funct7),
      .Funct3(Funct3), .start(start), .flush(flush),
      .operand_a(operand_a), .operand_b(operand_b),
      .is_muldiv(is_md1), .busy(busy1), .done(done1), .result(res1));

   // Reference: RISC-V M semantics with plain 64-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
      logic signed [63:0] as, bs, p;
      logic [63:0]        au, bu, pu;
      logic               ovf;
      logic [31:0]        r;
      as  = {{32{a[31]}}, a};
      bs  = {{32{b[31]}}, b};
      au  = {32'd0, a};
      bu  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r   = 32'd0;
      case (f3)
         3'd0: begin pu = au * bu; r = pu[31:0]; end
         3'd1: begin p = as * bs; r = p[63:32]; end
         3'd2: begin p = as * $signed(bu); r = p[63:32]; end
         3'd3: begin pu = au * bu; r = pu[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (ovf) r = 32'h8000_0000;
            else begin p = as / bs; r = p[31:0]; end
         end
         3'd5: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else begin pu = au / bu; r = pu[31:0]; end
         end
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (ovf) r = 32'd0;
            else begin p = as % bs; r = p[31:0]; end
         end
         default: begin
            if (b == 32'd0) r = a;
            else begin pu = au % bu; r = pu[31:0]; end
         end
      endcase
      return r;
   endfunction

   function automatic logic ref_fast(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
      return f3[2] && ((b == 32'd0) ||
             (((f3 == 3'd4) || (f3 == 3'd6)) &&
              (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, want);
      end
   endtask

   task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b);
      @(posedge clk);
      #1;
      ALUOp     = 2'b10;
      Funct7    = 7'b0000001;
      Funct3    = f3;
      operand_a = a;
      operand_b = b;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Watch both DUTs for up to ncyc cycles after the accept edge.
   task automatic monitor(input int ncyc, input bit stop_on_done,
                          input int flush_at, input int rst_at,
                          input int hold_to);
      for (int d = 0; d < 2; d++) begin
         mon_lat[d] = 0; mon_nd[d] = 0; mon_bcnt[d] = 0;
         mon_blast[d] = 0; mon_res[d] = 32'd0;
      end
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         flush   = (k == flush_at);
         reset_n = (k != rst_at);
         if (hold_to > 0) begin
            start     = (k < hold_to);
            operand_a = 32'd9;
         end
         #1;
         if (k == rst_at) begin
            check("reset busy", {31'd0, busy0 | busy1}, 32'd0);
            check("reset done", {31'd0, done0 | done1}, 32'd0);
            check("reset result slow", res0, 32'd0);
            check("reset result fast", res1, 32'd0);
         end
         for (int d = 0; d < 2; d++) begin
            logic        bz, dn;
            logic [31:0] rv;
            bz = (d == 0) ? busy0 : busy1;
            dn = (d == 0) ? done0 : done1;
            rv = (d == 0) ? res0 : res1;
            if (dn) begin
               mon_nd[d]++;
               if (mon_lat[d] == 0) begin
                  mon_lat[d] = k;
                  mon_res[d] = rv;
               end
            end
            if (bz) begin
               mon_bcnt[d]++;
               mon_blast[d] = k;
            end
         end
         if (stop_on_done && done0) break;
      end
      flush   = 1'b0;
      reset_n = 1'b1;
      if (hold_to > 0) start = 1'b0;
   endtask

   task automatic check_op(input string tag, input logic [31:0] want,
                           input logic fast);
      for (int d = 0; d < 2; d++) begin
         int el;
         el = (d == 1 && fast) ? 1 : LAT;
         check($sformatf("%s latency dut%0d", tag, d), 32'(mon_lat[d]), 32'(el));
         check($sformatf("%s done count dut%0d", tag, d), 32'(mon_nd[d]), 32'd1);
         check($sformatf("%s result dut%0d", tag, d), mon_res[d], want);
         check($sformatf("%s busy cycles dut%0d", tag, d), 32'(mon_bcnt[d]), 32'(el));
         check($sformatf("%s busy last dut%0d", tag, d), 32'(mon_blast[d]), 32'(el));
         check($sformatf("%s result held dut%0d", tag, d),
               (d == 0) ? res0 : res1, want);
      end
      last_want = want;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] want, input logic fast);
      issue(f3, a, b);
      monitor(LAT + 6, 1'b0, 0, 0, 0);
      check_op(tag, want, fast);
   endtask

   // Aborted op: no done, busy for the given number of cycles, result unchanged.
   task automatic check_abort(input string tag, input int bcycles,
                              input logic [31:0] keep);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("%s done count dut%0d", tag, d), 32'(mon_nd[d]), 32'd0);
         check($sformatf("%s busy cycles dut%0d", tag, d), 32'(mon_bcnt[d]), 32'(bcycles));
         check($sformatf("%s busy last dut%0d", tag, d), 32'(mon_blast[d]), 32'(bcycles));
         check($sformatf("%s result kept dut%0d", tag, d),
               (d == 0) ? res0 : res1, keep);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
      vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
      vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0};
      vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
      vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
      vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        1'b0};
      vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
      vecs[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
      vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1'b1};
      vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
      vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1};
      vecs[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
      vecs[13] = '{3'd7, 32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 1'b1};
      vecs[14] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1'b1};
      vecs[15] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0};
      vecs[16] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0};
      vecs[17] = '{3'd0, 32'h8000_0000,  32'h8000_0000, 32'd0,         1'b0};
      vecs[18] = '{3'd4, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0};
      vecs[19] = '{3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0};

      reset_n = 1'b0; ALUOp = 2'b00; Funct7 = 7'd0; Funct3 = 3'd0;
      start = 1'b0; flush = 1'b0; operand_a = 32'd0; operand_b = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("in-reset busy", {30'd0, busy1, busy0}, 32'd0);
      check("in-reset done", {30'd0, done1, done0}, 32'd0);
      reset_n = 1'b1;
      #1;
      check("post-reset result slow", res0, 32'd0);
      check("post-reset result fast", res1, 32'd0);
      check("post-reset busy", {30'd0, busy1, busy0}, 32'd0);

      // Decode: Funct7 = 0 is a base ALU op and must not be accepted.
      ALUOp = 2'b10; Funct7 = 7'b0000000; operand_a = 32'd3; operand_b = 32'd4;
      start = 1'b1;
      #1;
      check("decode f7=0", {30'd0, is_md1, is_md0}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("decode f7=0 busy", {30'd0, busy1, busy0}, 32'd0);
      start = 1'b0;
      Funct7 = 7'b0000001;
      #1;
      check("decode m op", {30'd0, is_md1, is_md0}, 32'd3);
      ALUOp = 2'b00;
      #1;
      check("decode aluop 00", {30'd0, is_md1, is_md0}, 32'd0);
      ALUOp = 2'b11;
      #1;
      check("decode aluop 11", {30'd0, is_md1, is_md0}, 32'd0);

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                vecs[i].want, vecs[i].fast);

      // Flush in the middle of a divide.
      issue(3'd5, 32'd1000, 32'd3);
      monitor(LAT + 6, 1'b0, 10, 0, 0);
      check_abort("flush c10", 10, last_want);

      // Flush in the final cycle beats completion.
      issue(3'd0, 32'd11, 32'd13);
      monitor(LAT + 6, 1'b0, LAT, 0, 0);
      check_abort("flush fin", LAT, last_want);

      run_op("mul after flush", 3'd0, 32'd3, 32'd4, 32'd12, 1'b0);

      // Asynchronous reset in the middle of a multiply.
      issue(3'd0, 32'h1234, 32'd5);
      monitor(LAT + 6, 1'b0, 0, 20, 0);
      check_abort("reset mid-op", 19, 32'd0);

      // start held high while busy with changing operands: one op only.
      issue(3'd0, 32'd5, 32'd6);
      monitor(LAT + 10, 1'b0, 0, 0, 20);
      check_op("start held", 32'd30, 1'b0);

      // Back-to-back: second op accepted in the cycle after done.
      issue(3'd5, 32'd100, 32'd7);
      monitor(LAT + 6, 1'b1, 0, 0, 0);
      check("b2b first latency", 32'(mon_lat[0]), 32'(LAT));
      check("b2b first result", mon_res[0], 32'd14);
      issue(3'd7, 32'd100, 32'd7);
      monitor(LAT + 6, 1'b0, 0, 0, 0);
      check_op("b2b second", 32'd2, 1'b0);

      // Randomised ops against the reference model.
      for (int n = 0; n < 24; n++) begin
         logic [2:0]  f3;
         logic [31:0] a, b;
         int          sel;
         f3  = 3'($urandom_range(0, 7));
         a   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         sel = int'($urandom_range(0, 5));
         case (sel)
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 16));
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d f3=%0d a=%0h b=%0h", n, f3, a, b),
                f3, a, b, ref_model(f3, a, b), ref_fast(f3, a, b));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
